// File: rtl/act_lut_pkg.sv
// Shared widths, saturation bounds and data word type for the activation stage.
package act_lut_pkg;

  localparam int ACT_IN_W   = 8;
  localparam int ACT_ADDR_W = 4;
  localparam int ACT_FRAC_W = 4;
  localparam int ACT_DATA_W = 8;

  typedef logic signed [ACT_DATA_W-1:0] data_t;

  localparam data_t ACT_SAT_MAX = data_t'(2 ** (ACT_DATA_W - 1) - 1);
  localparam data_t ACT_SAT_MIN = data_t'(-(2 ** (ACT_DATA_W - 1)));

endpackage

// File: rtl/act_lut.sv
// Activation lookup table: returns the segment start (base) and the
// following breakpoint (next) for a signed segment index. The top positive
// index repeats its own entry so the curve saturates; index -1 wraps to
// entry 0 so the curve crosses zero continuously.
module act_lut
  import act_lut_pkg::*;
#(
  parameter int ADDR_WIDTH = ACT_ADDR_W,
  parameter int DATA_WIDTH = ACT_DATA_W
) (
  input  logic        [ADDR_WIDTH-1:0] addr,
  output logic signed [DATA_WIDTH-1:0] base_data,
  output logic signed [DATA_WIDTH-1:0] next_data
);

  localparam logic [ADDR_WIDTH-1:0] TOP_POS = {1'b0, {(ADDR_WIDTH-1){1'b1}}};

  logic [ADDR_WIDTH-1:0] next_addr;

  // Table contents: 0, 12, 15 x6, -15 x7, -12 (indexed as unsigned 0..15).
  function automatic logic signed [DATA_WIDTH-1:0] lut_entry(
    input logic [ADDR_WIDTH-1:0] idx
  );
    logic signed [DATA_WIDTH-1:0] v;
    if (idx == '0) begin
      v = '0;
    end else if (idx == ADDR_WIDTH'(1)) begin
      v = DATA_WIDTH'(12);
    end else if (idx <= ADDR_WIDTH'(7)) begin
      v = DATA_WIDTH'(15);
    end else if (idx <= ADDR_WIDTH'(14)) begin
      v = DATA_WIDTH'(-15);
    end else begin
      v = DATA_WIDTH'(-12);
    end
    return v;
  endfunction

  // Resolve base/next entries, including both index edge cases.
  always_comb begin
    next_addr = addr + ADDR_WIDTH'(1);
    base_data = lut_entry(addr);
    if (addr == TOP_POS) begin
      next_data = base_data;
    end else begin
      next_data = lut_entry(next_addr);
    end
  end

endmodule

// File: rtl/act_lut_interp.sv
// Three-stage piecewise-linear activation: index/fraction capture, LUT read,
// then interpolate with floor rounding and saturate. A single advance signal
// stalls the whole pipe when the output is held by the consumer.
module act_lut_interp
  import act_lut_pkg::*;
#(
  parameter int IN_WIDTH   = ACT_IN_W,
  parameter int ADDR_WIDTH = ACT_ADDR_W,
  parameter int FRAC_WIDTH = ACT_FRAC_W,
  parameter int DATA_WIDTH = ACT_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [IN_WIDTH-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data
);

  localparam int DIFF_W = DATA_WIDTH + 1;
  localparam int PROD_W = DATA_WIDTH + FRAC_WIDTH + 2;

  localparam logic signed [PROD_W-1:0] SAT_HI =
    {{(PROD_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_LO =
    {{(PROD_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic adv;

  logic                         vld_p1_d,  vld_p1_q;
  logic        [ADDR_WIDTH-1:0] addr_p1_d, addr_p1_q;
  logic        [FRAC_WIDTH-1:0] frac_p1_d, frac_p1_q;

  logic signed [DATA_WIDTH-1:0] lut_base, lut_next;

  logic                         vld_p2_d,  vld_p2_q;
  logic signed [DATA_WIDTH-1:0] base_p2_d, base_p2_q;
  logic signed [DATA_WIDTH-1:0] next_p2_d, next_p2_q;
  logic        [FRAC_WIDTH-1:0] frac_p2_d, frac_p2_q;

  logic                         out_valid_d, out_valid_q;
  logic signed [DATA_WIDTH-1:0] out_data_d,  out_data_q;

  // base + floor((next - base) * frac / 2^FRAC); full precision, no wrap.
  function automatic logic signed [PROD_W-1:0] interp_floor(
    input logic signed [DATA_WIDTH-1:0] bse,
    input logic signed [DATA_WIDTH-1:0] nxt,
    input logic        [FRAC_WIDTH-1:0] frc
  );
    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] prod;
    diff = DIFF_W'(nxt) - DIFF_W'(bse);
    prod = PROD_W'(diff) * PROD_W'($signed({1'b0, frc}));
    return PROD_W'(bse) + (prod >>> FRAC_WIDTH);
  endfunction

  // Clamp a wide signed value into the output word range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_data(
    input logic signed [PROD_W-1:0] v
  );
    logic signed [PROD_W-1:0] c;
    if (v > SAT_HI) begin
      c = SAT_HI;
    end else if (v < SAT_LO) begin
      c = SAT_LO;
    end else begin
      c = v;
    end
    return c[DATA_WIDTH-1:0];
  endfunction

  act_lut #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lut (
    .addr      (addr_p1_q),
    .base_data (lut_base),
    .next_data (lut_next)
  );

  // Next-state for every stage; everything holds together when adv is low.
  always_comb begin
    adv = !out_valid_q | out_ready;

    vld_p1_d    = vld_p1_q;
    addr_p1_d   = addr_p1_q;
    frac_p1_d   = frac_p1_q;
    vld_p2_d    = vld_p2_q;
    base_p2_d   = base_p2_q;
    next_p2_d   = next_p2_q;
    frac_p2_d   = frac_p2_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (adv) begin
      // p1: split input into segment index and fraction
      vld_p1_d    = in_valid;
      addr_p1_d   = in_data[IN_WIDTH-1 -: ADDR_WIDTH];
      frac_p1_d   = in_data[FRAC_WIDTH-1:0];
      // p2: capture LUT endpoints
      vld_p2_d    = vld_p1_q;
      base_p2_d   = lut_base;
      next_p2_d   = lut_next;
      frac_p2_d   = frac_p1_q;
      // output: interpolate and saturate
      out_valid_d = vld_p2_q;
      out_data_d  = sat_data(interp_floor(base_p2_q, next_p2_q, frac_p2_q));
    end
  end

  // Valid chain and output word: cleared by reset so in-flight data is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Internal datapath registers: meaningful only alongside their valid bit.
  always_ff @(posedge clk) begin
    addr_p1_q <= addr_p1_d;
    frac_p1_q <= frac_p1_d;
    base_p2_q <= base_p2_d;
    next_p2_q <= next_p2_d;
    frac_p2_q <= frac_p2_d;
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_act_lut_interp.sv
// Bench for act_lut_interp: directed vectors with literal expectations, a
// spec-level arithmetic model feeding an in-order scoreboard, and per-cycle
// stall/hold checks.
module tb_act_lut_interp;
  import act_lut_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  data_t       out_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int c0       = 0;
  int exp_q[$];
  int obs_q[$];
  int obs_cyc[$];
  bit prev_stall = 1'b0;
  int held       = 0;
  bit rand_done  = 1'b0;
  logic [7:0] rx;

  int LUT [16] = '{0, 12, 15, 15, 15, 15, 15, 15,
                   -15, -15, -15, -15, -15, -15, -15, -12};
  logic [7:0] burst_in  [4] = '{8'h18, 8'h7F, 8'hF8, 8'h88};
  int         burst_exp [4] = '{13, 15, -6, -15};
  int         stall_exp [4] = '{6, 13, 15, -6};
  logic [7:0] pin_in    [10] = '{8'h08, 8'h18, 8'h7F, 8'hF8, 8'h88,
                                 8'hF0, 8'h00, 8'h70, 8'h8F, 8'hE8};
  int         pin_exp   [10] = '{6, 13, 15, -6, -15, -12, 0, 15, -15, -14};

  always #5 clk = ~clk;

  act_lut_interp dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int floor_div16(int p);
    if (p >= 0) return p / 16;
    return -((-p + 15) / 16);
  endfunction

  // Straight from the activation rules: segment lookup, linear blend, clamp.
  function automatic int model_act(logic [7:0] x);
    int idx, frac, base, nxt, y;
    idx  = int'(x[7:4]);
    frac = int'(x[3:0]);
    base = LUT[idx];
    nxt  = (idx == 7) ? base : LUT[(idx + 1) % 16];
    y    = base + floor_div16((nxt - base) * frac);
    if (y > int'(ACT_SAT_MAX)) y = int'(ACT_SAT_MAX);
    if (y < int'(ACT_SAT_MIN)) y = int'(ACT_SAT_MIN);
    return y;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Per-cycle scoreboard and stall behaviour checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) chk("hold_data", int'(out_data), held);
      if (out_valid && !out_ready) chk("stall_in_ready", int'(in_ready), 0);
      if (in_valid && in_ready) exp_q.push_back(model_act(in_data));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%0d required=none", int'(out_data));
        end else begin
          chk("stream", int'(out_data), exp_q.pop_front());
        end
        obs_q.push_back(int'(out_data));
        obs_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      held       = int'(out_data);
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] x);
    int n   = 0;
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    idle(2);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", int'(in_ready), 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) chk("model_pin", model_act(pin_in[i]), pin_exp[i]);

    // Single item latency
    clear_obs();
    c0 = cyc;
    send(8'h08);
    idle(4);
    chk("t1_count", obs_q.size(), 1);
    if (obs_q.size() >= 1) begin
      chk("t1_data", obs_q[0], 6);
      chk("t1_latency", obs_cyc[0] - c0, 3);
    end

    // Back-to-back burst across both LUT edges
    clear_obs();
    for (int i = 0; i < 4; i++) send(burst_in[i]);
    idle(6);
    chk("t2_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t2_data", obs_q[i], burst_exp[i]);
        chk("t2_consecutive", obs_cyc[i] - obs_cyc[0], i);
      end
    end

    // Full-pipe stall with a pending input
    clear_obs();
    out_ready = 1'b0;
    send(8'h08);
    send(8'h18);
    send(8'h7F);
    in_valid = 1'b1;
    in_data  = 8'hF8;
    repeat (5) begin
      @(negedge clk);
      chk("t3_in_ready", int'(in_ready), 0);
      chk("t3_out_valid", int'(out_valid), 1);
      chk("t3_out_data", int'(out_data), 6);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'hF8);
    idle(8);
    chk("t3_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t3_data", obs_q[i], stall_exp[i]);
    end

    // Reset with items in flight
    out_ready = 1'b1;
    send(8'h18);
    send(8'h7F);
    send(8'hF8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_rst_out_valid", int'(out_valid), 0);
    chk("t4_rst_out_data", int'(out_data), 0);
    rst = 1'b0;
    clear_obs();
    send(8'hF0);
    idle(5);
    chk("t4_count", obs_q.size(), 1);
    if (obs_q.size() >= 1) chk("t4_data", obs_q[0], -12);

    // Random valid/ready traffic against the model
    clear_obs();
    rand_done = 1'b0;
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #2;
          if (!rand_done) out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 1000; i++) begin
      idle($urandom_range(0, 2));
      rx = 8'($urandom);
      send(rx);
    end
    rand_done = 1'b1;
    @(posedge clk);
    #3;
    out_ready = 1'b1;
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(posedge clk);
        n++;
      end
    end
    idle(2);
    chk("t5_drain_empty", exp_q.size(), 0);
    chk("t5_count", obs_q.size(), 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
